// File: rtl/prog_loader_pkg.sv
// Shared types and default sizes for the programme loader sequencer.
package prog_loader_pkg;

    localparam int QUINTET_W     = 5;
    localparam int WORD_QUINTETS = 3;
    localparam int ADDR_WIDTH    = 3;
    localparam int WORD_W        = 15;

    // Encoding is visible on state_o, so values are pinned.
    typedef enum logic [1:0] {
        S_LOAD   = 2'd0,
        S_HALTED = 2'd1,
        S_RUN    = 2'd2,
        S_STEP   = 2'd3
    } state_e;

endpackage

// File: rtl/prog_loader_ctrl_if.sv
// Load-beat, instruction-memory write and CPU control bundle of prog_loader_ctrl.
interface prog_loader_if
    import prog_loader_pkg::*;
#(
    parameter int QW = QUINTET_W,
    parameter int AW = ADDR_WIDTH
) ();

    logic              load_valid;
    logic [QW-1:0]     load_data;
    logic              load_ready;
    logic              reload;
    logic              run;
    logic              step;
    logic              imem_wr;
    logic [AW-1:0]     imem_waddr;
    logic [WORD_W-1:0] imem_wdata;
    logic              cpu_en;
    logic              cpu_rst;
    logic [1:0]        state_o;
    logic [WORD_W-1:0] load_csum;

    // Controller side.
    modport slave (
        input  load_valid, load_data, reload, run, step,
        output load_ready, imem_wr, imem_waddr, imem_wdata,
               cpu_en, cpu_rst, state_o, load_csum
    );

    // Loader source / SoC side.
    modport master (
        output load_valid, load_data, reload, run, step,
        input  load_ready, imem_wr, imem_waddr, imem_wdata,
               cpu_en, cpu_rst, state_o, load_csum
    );

endinterface

// File: rtl/prog_loader_ctrl_quintet_packer.sv
// Packs quintet beats into one instruction word and raises a one-cycle write strobe.
module quintet_packer
    import prog_loader_pkg::*;
#(
    parameter int QW = QUINTET_W,
    parameter int WQ = WORD_QUINTETS
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_clr,
    input  logic             i_en,
    input  logic             i_valid,
    input  logic [QW-1:0]    i_data,
    output logic             o_ready,
    output logic             o_wr,
    output logic [QW*WQ-1:0] o_wdata
);

    localparam int CNT_W = (WQ > 1) ? $clog2(WQ) : 1;

    logic [CNT_W-1:0] r_cnt;
    logic [QW*WQ-1:0] r_data;
    logic             r_wr;
    logic             w_accept;

    // Beats stall during the write cycle so the word is stable while written.
    assign o_ready  = i_en & ~r_wr;
    assign w_accept = i_valid & o_ready;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt  <= '0;
            r_data <= '0;
            r_wr   <= 1'b0;
        end else if (i_clr) begin
            r_cnt  <= '0;
            r_data <= '0;
            r_wr   <= 1'b0;
        end else begin
            r_wr <= 1'b0;
            if (w_accept) begin
                for (int k = 0; k < WQ; k++) begin
                    if (r_cnt == CNT_W'(k)) r_data[k*QW +: QW] <= i_data;
                end
                if (r_cnt == CNT_W'(WQ-1)) begin
                    r_cnt <= '0;
                    r_wr  <= 1'b1;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end
    end

    assign o_wr    = r_wr;
    assign o_wdata = r_data;

endmodule

// File: rtl/prog_loader_ctrl.sv
// Programme loader and CPU run/halt/step sequencer.
// Optional load checksum register enabled by defining PROG_LOADER_CSUM_EN.
module prog_loader_ctrl
    import prog_loader_pkg::*;
#(
    parameter int QUINTET_W     = prog_loader_pkg::QUINTET_W,
    parameter int WORD_QUINTETS = prog_loader_pkg::WORD_QUINTETS,
    parameter int ADDR_WIDTH    = prog_loader_pkg::ADDR_WIDTH
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    prog_loader_if.slave bus
);

    state_e                r_state;
    state_e                w_next;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic                  w_is_load;
    logic                  w_wr;
    logic [WORD_W-1:0]     w_wdata;

    assign w_is_load = (r_state == S_LOAD);

    quintet_packer #(
        .QW (QUINTET_W),
        .WQ (WORD_QUINTETS)
    ) u_packer (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_clr   (bus.reload),
        .i_en    (w_is_load),
        .i_valid (bus.load_valid),
        .i_data  (bus.load_data),
        .o_ready (bus.load_ready),
        .o_wr    (w_wr),
        .o_wdata (w_wdata)
    );

    // Address advances after each write and wraps naturally at the memory depth.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)        r_addr <= '0;
        else if (bus.reload) r_addr <= '0;
        else if (w_wr)       r_addr <= r_addr + 1'b1;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= S_LOAD;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        if (bus.reload) begin
            w_next = S_LOAD;
        end else begin
            unique case (r_state)
                S_LOAD:   if (w_wr && (r_addr == '1)) w_next = S_HALTED;
                S_HALTED: begin
                    if (bus.run)       w_next = S_RUN;
                    else if (bus.step) w_next = S_STEP;
                end
                S_RUN:    if (!bus.run) w_next = S_HALTED;
                S_STEP:   w_next = S_HALTED;
                default:  w_next = S_LOAD;
            endcase
        end
    end

    assign bus.imem_wr    = w_wr;
    assign bus.imem_waddr = r_addr;
    assign bus.imem_wdata = w_wdata;
    assign bus.cpu_rst    = w_is_load;
    assign bus.cpu_en     = (r_state == S_RUN) | (r_state == S_STEP);
    assign bus.state_o    = r_state;

`ifdef PROG_LOADER_CSUM_EN
    logic [WORD_W-1:0] r_csum;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)        r_csum <= '0;
        else if (bus.reload) r_csum <= '0;
        else if (w_wr)       r_csum <= r_csum ^ w_wdata;
    end

    assign bus.load_csum = r_csum;
`else
    assign bus.load_csum = '0;
`endif

endmodule

// File: tb/tb_prog_loader_ctrl.sv
// Directed bench for prog_loader_ctrl: load sequences, run/halt/step table, reload and reset corners.
module tb_prog_loader_ctrl;
    import prog_loader_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    prog_loader_if #(.QW(5), .AW(3)) bus ();

    prog_loader_ctrl dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    typedef struct {
        logic [2:0]  a;
        logic [14:0] d;
    } wr_t;

    typedef struct {
        logic       run, step, reload, lv;
        logic [1:0] st;
        logic       en, rdy;
    } vec_t;

    int          n_cmp = 0;
    int          n_fail = 0;
    int          n_wr = 0;
    int          wr_mark;
    logic [2:0]  exp_addr = '0;
    logic [14:0] exp_csum = '0;
    wr_t         exp_q[$];
    wr_t         cur;
    vec_t        vt[26];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [14:0] csum_exp();
`ifdef PROG_LOADER_CSUM_EN
        return exp_csum;
`else
        return 15'h0;
`endif
    endfunction

    // Every write must match the next fully delivered word, and never overlap a beat.
    always @(negedge clk) begin
        if (rst_n && bus.imem_wr) begin
            n_wr++;
            chk("ready_in_wr_cycle", 32'(bus.load_ready), 32'd0);
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_wr: addr %0d data %h with no word pending", bus.imem_waddr, bus.imem_wdata);
            end else begin
                cur = exp_q.pop_front();
                chk("imem_waddr", 32'(bus.imem_waddr), 32'(cur.a));
                chk("imem_wdata", 32'(bus.imem_wdata), 32'(cur.d));
                exp_csum = exp_csum ^ cur.d;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_beat(input logic [4:0] d);
        int guard;
        guard = 0;
        bus.load_valid = 1'b1;
        bus.load_data  = d;
        @(negedge clk);
        while (!bus.load_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 20) chk("beat_timeout", 32'(bus.load_ready), 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic send_word(input logic [14:0] w, input int nbeats);
        for (int b = 0; b < nbeats; b++) send_beat(w[b*5 +: 5]);
        if (nbeats == 3) begin
            exp_q.push_back('{a: exp_addr, d: w});
            exp_addr = exp_addr + 3'd1;
        end
    endtask

    task automatic pulse_reload();
        bus.reload = 1'b1;
        tick();
        bus.reload = 1'b0;
        exp_addr = '0;
        exp_csum = '0;
        exp_q.delete();
    endtask

    initial begin
        bus.load_valid = 1'b0;
        bus.load_data  = '0;
        bus.reload     = 1'b0;
        bus.run        = 1'b0;
        bus.step       = 1'b0;

        //            run step rel lv  st     en rdy
        vt = '{
            '{1'b1, 1'b0, 1'b0, 1'b0, 2'd2, 1'b1, 1'b0},
            '{1'b1, 1'b0, 1'b0, 1'b0, 2'd2, 1'b1, 1'b0},
            '{1'b1, 1'b1, 1'b0, 1'b0, 2'd2, 1'b1, 1'b0},
            '{1'b1, 1'b0, 1'b0, 1'b0, 2'd2, 1'b1, 1'b0},
            '{1'b1, 1'b0, 1'b0, 1'b0, 2'd2, 1'b1, 1'b0},
            '{1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 1'b0, 1'b0},
            '{1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 1'b0, 1'b0},
            '{1'b0, 1'b1, 1'b0, 1'b0, 2'd3, 1'b1, 1'b0},
            '{1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 1'b0, 1'b0},
            '{1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 1'b0, 1'b0},
            '{1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 1'b0, 1'b0},
            '{1'b0, 1'b1, 1'b0, 1'b0, 2'd3, 1'b1, 1'b0},
            '{1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 1'b0, 1'b0},
            '{1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 1'b0, 1'b0},
            '{1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 1'b0, 1'b0},
            '{1'b0, 1'b1, 1'b0, 1'b0, 2'd3, 1'b1, 1'b0},
            '{1'b0, 1'b1, 1'b0, 1'b0, 2'd1, 1'b0, 1'b0},
            '{1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 1'b0, 1'b0},
            '{1'b1, 1'b1, 1'b0, 1'b0, 2'd2, 1'b1, 1'b0},
            '{1'b0, 1'b0, 1'b0, 1'b1, 2'd1, 1'b0, 1'b0},
            '{1'b0, 1'b0, 1'b0, 1'b1, 2'd1, 1'b0, 1'b0},
            '{1'b1, 1'b0, 1'b0, 1'b1, 2'd2, 1'b1, 1'b0},
            '{1'b1, 1'b0, 1'b0, 1'b1, 2'd2, 1'b1, 1'b0},
            '{1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 1'b0, 1'b0},
            '{1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 1'b0, 1'b1},
            '{1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1}
        };

        // Reset values
        #12;
        chk("rst_state", 32'(bus.state_o), 32'd0);
        chk("rst_cpu_rst", 32'(bus.cpu_rst), 32'd1);
        chk("rst_cpu_en", 32'(bus.cpu_en), 32'd0);
        chk("rst_imem_wr", 32'(bus.imem_wr), 32'd0);
        chk("rst_waddr", 32'(bus.imem_waddr), 32'd0);
        chk("rst_wdata", 32'(bus.imem_wdata), 32'd0);
        chk("rst_csum", 32'(bus.load_csum), 32'd0);
        chk("rst_ready", 32'(bus.load_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Full back-to-back load of 15'h1000+n
        for (int n = 0; n < 8; n++) send_word(15'h1000 + 15'(n), 3);
        bus.load_valid = 1'b0;
        chk("last_wr_strobe", 32'(bus.imem_wr), 32'd1);
        chk("last_wr_addr", 32'(bus.imem_waddr), 32'd7);
        chk("state_during_last_wr", 32'(bus.state_o), 32'd0);
        tick();
        chk("state_after_load", 32'(bus.state_o), 32'd1);
        chk("cpu_rst_after_load", 32'(bus.cpu_rst), 32'd0);
        chk("cpu_en_after_load", 32'(bus.cpu_en), 32'd0);
        chk("wr_count_load1", 32'(n_wr), 32'd8);
        chk("csum_load1", 32'(bus.load_csum), 32'(csum_exp()));

        // Run / halt / step / beats-outside-load / reload+step table
        wr_mark = n_wr;
        for (int i = 0; i < 26; i++) begin
            bus.run        = vt[i].run;
            bus.step       = vt[i].step;
            bus.reload     = vt[i].reload;
            bus.load_valid = vt[i].lv;
            bus.load_data  = vt[i].lv ? 5'h1F : 5'h00;
            tick();
            chk($sformatf("vec%0d_state", i), 32'(bus.state_o), 32'(vt[i].st));
            chk($sformatf("vec%0d_cpu_en", i), 32'(bus.cpu_en), 32'(vt[i].en));
            chk($sformatf("vec%0d_ready", i), 32'(bus.load_ready), 32'(vt[i].rdy));
            chk($sformatf("vec%0d_cpu_rst", i), 32'(bus.cpu_rst), 32'(vt[i].st == 2'd0));
        end
        bus.run = 1'b0; bus.step = 1'b0; bus.reload = 1'b0; bus.load_valid = 1'b0;
        chk("no_wr_outside_load", 32'(n_wr), 32'(wr_mark));
        exp_addr = '0;
        exp_csum = '0;

        // Reload mid-word: three full words, two beats of the fourth, then reload
        send_word(15'h0AAA, 3);
        send_word(15'h1555, 3);
        send_word(15'h7FFF, 3);
        send_word(15'h3C3C, 2);
        bus.load_valid = 1'b0;
        tick();
        tick();
        chk("wr_count_partial", 32'(n_wr), 32'(wr_mark + 3));
        chk("csum_partial", 32'(bus.load_csum), 32'(csum_exp()));
        pulse_reload();
        chk("state_after_reload", 32'(bus.state_o), 32'd0);
        chk("csum_after_reload", 32'(bus.load_csum), 32'd0);
        tick();
        chk("partial_word_dropped", 32'(n_wr), 32'(wr_mark + 3));

        // Reload of one-hot words 15'h0001..15'h0080
        for (int n = 0; n < 8; n++) send_word(15'h0001 << n, 3);
        bus.load_valid = 1'b0;
        tick();
        chk("state_after_reload_load", 32'(bus.state_o), 32'd1);
        chk("wr_count_reload", 32'(n_wr), 32'(wr_mark + 11));
        chk("csum_final", 32'(bus.load_csum), 32'(csum_exp()));
`ifdef PROG_LOADER_CSUM_EN
        chk("csum_value", 32'(bus.load_csum), 32'h00FF);
`endif
        chk("exp_queue_drained", 32'(exp_q.size()), 32'd0);

        // Asynchronous reset while running
        bus.run = 1'b1;
        tick();
        chk("run_before_rst", 32'(bus.state_o), 32'd2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_state", 32'(bus.state_o), 32'd0);
        chk("async_rst_cpu_rst", 32'(bus.cpu_rst), 32'd1);
        chk("async_rst_cpu_en", 32'(bus.cpu_en), 32'd0);
        chk("async_rst_csum", 32'(bus.load_csum), 32'd0);
        bus.run = 1'b0;
        #20;
        rst_n = 1'b1;
        tick();
        chk("post_rst_state", 32'(bus.state_o), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
